// File: rtl/zfifo_pkg.sv
// rtl/zfifo_pkg.sv - shared defaults and occupancy next-state function for the Z-buffer FIFO
package zfifo_pkg;

    localparam int PIX_W_DEF = 16;
    localparam int Z_W_DEF   = 16;
    localparam int DEPTH_DEF = 16;

    // Flush wins over push and pop; a simultaneous push and pop leaves occupancy unchanged.
    function automatic logic [31:0] fill_next(
        input logic [31:0] fill,
        input logic        push,
        input logic        pop,
        input logic        flush
    );
        logic [31:0] nxt;
        nxt = fill;
        if (flush) begin
            nxt = '0;
        end else if (push && !pop) begin
            nxt = fill + 32'd1;
        end else if (pop && !push) begin
            nxt = fill - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/zfifo_ptr.sv
// rtl/zfifo_ptr.sv - wrapping FIFO pointer with synchronous clear
module zfifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/zpix_fifo.sv
// rtl/zpix_fifo.sv - first-word-fall-through (pixel, depth) FIFO; ZFIFO_HWM_EN adds the hwm high-water port
module zpix_fifo
    import zfifo_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PIX_WIDTH = PIX_W_DEF,
    parameter int Z_WIDTH   = Z_W_DEF,
    parameter int AF_THRESH = 14,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_WIDTH-1:0] in_pix,
    input  logic [Z_WIDTH-1:0]   in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_WIDTH-1:0] out_pix,
    output logic [Z_WIDTH-1:0]   out_z,
    input  logic                 flush,
    output logic [ADDR_W:0]      fill,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full
`ifdef ZFIFO_HWM_EN
    ,
    output logic [ADDR_W:0]      hwm
`endif
);

    localparam int ENTRY_W = PIX_WIDTH + Z_WIDTH;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    fill_q;
    logic [ADDR_W:0]    fill_d;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Handshake flags come only from registered occupancy, so no ready-to-ready path exists.
    assign full        = (fill_q == (ADDR_W+1)'(DEPTH));
    assign empty       = (fill_q == '0);
    assign almost_full = (fill_q >= (ADDR_W+1)'(AF_THRESH));
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign fill        = fill_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign fill_d = (ADDR_W+1)'(fill_next(32'(fill_q), push, pop, flush));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    zfifo_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    zfifo_ptr #(.W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    // Storage is deliberately unreset; a flushed push is not written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr] <= {in_pix, in_z};
        end
    end

    assign head    = mem_q[rd_ptr];
    assign out_pix = head[ENTRY_W-1:Z_WIDTH];
    assign out_z   = head[Z_WIDTH-1:0];

`ifdef ZFIFO_HWM_EN
    logic [ADDR_W:0] hwm_q;
    logic [ADDR_W:0] hwm_d;

    // fill never exceeds DEPTH, so tracking the maximum saturates by construction.
    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (fill_d > hwm_q) begin
            hwm_d = fill_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_zpix_fifo.sv
// tb/tb_zpix_fifo.sv - directed self-checking bench for zpix_fifo
module tb_zpix_fifo;
    import zfifo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pix;
    logic [15:0] in_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pix;
    logic [15:0] out_z;
    logic        flush;
    logic [4:0]  fill;
    logic        full;
    logic        empty;
    logic        almost_full;
`ifdef ZFIFO_HWM_EN
    logic [4:0]  hwm;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic [31:0] fill_m;
    logic [31:0] hwm_m;

    zpix_fifo #(
        .DEPTH     (16),
        .PIX_WIDTH (16),
        .Z_WIDTH   (16),
        .AF_THRESH (14)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pix      (in_pix),
        .in_z        (in_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pix     (out_pix),
        .out_z       (out_z),
        .flush       (flush),
        .fill        (fill),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
`ifdef ZFIFO_HWM_EN
        ,
        .hwm         (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: pre-edge handshake/head checks, post-edge occupancy checks.
    task automatic cycle(input logic iv, input logic [15:0] p, input logic [15:0] zz,
                         input logic orr, input logic fl);
        int   sz;
        logic ep;
        logic eo;
        sz        = exp_q.size();
        in_valid  = iv;
        in_pix    = p;
        in_z      = zz;
        out_ready = orr;
        flush     = fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(sz < 16));
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        if (sz > 0) begin
            chk("out_pix", 32'(out_pix), 32'(exp_q[0][31:16]));
            chk("out_z", 32'(out_z), 32'(exp_q[0][15:0]));
        end
        ep = iv && (sz < 16);
        eo = orr && (sz > 0);
        @(posedge clk);
        #1;
        fill_m = fill_next(fill_m, ep, eo, fl);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (eo) void'(exp_q.pop_front());
            if (ep) exp_q.push_back({p, zz});
        end
        if (fl) hwm_m = 0;
        else if (fill_m > hwm_m) hwm_m = fill_m;
        chk("fill", 32'(fill), fill_m);
        chk("fill_vs_queue", 32'(fill), 32'(exp_q.size()));
        chk("empty", 32'(empty), 32'(fill_m == 0));
        chk("full", 32'(full), 32'(fill_m == 16));
        chk("almost_full", 32'(almost_full), 32'(fill_m >= 14));
`ifdef ZFIFO_HWM_EN
        chk("hwm", 32'(hwm), hwm_m);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        in_z      = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        fill_m    = 0;
        hwm_m     = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
`ifdef ZFIFO_HWM_EN
        chk("rst_hwm", 32'(hwm), 32'd0);
`endif
        rst_n = 1'b1;

        // 16 pushes with no consumer.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 16'(i), 16'(100 + i), 1'b0, 1'b0);
            chk("fill_step", 32'(fill), 32'(i + 1));
        end
        chk("full_after16", 32'(full), 32'd1);
        chk("in_ready_after16", 32'(in_ready), 32'd0);
        chk("af_after16", 32'(almost_full), 32'd1);
        cycle(1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b0);
        chk("push17_ignored", 32'(fill), 32'd16);
        chk("head_after17", 32'(out_pix), 32'd0);

        // Drain 16.
        for (int i = 0; i < 16; i++) begin
            chk("drain_pix", 32'(out_pix), 32'(i));
            chk("drain_z", 32'(out_z), 32'(100 + i));
            cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_fill", 32'(fill), 32'd0);

        // Fill to 8, then 40 cycles of simultaneous push and pop.
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'(200 + i), 16'(300 + i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            chk("stream_pix", 32'(out_pix), 32'(200 + k));
            cycle(1'b1, 16'(208 + k), 16'(308 + k), 1'b1, 1'b0);
        end
        chk("stream_fill", 32'(fill), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("stream_tail", 32'(out_pix), 32'(240 + i));
            cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        end

        // Full FIFO, push and pop together: only the pop is taken.
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(500 + i), 16'(600 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'h7777, 16'h8888, 1'b1, 1'b0);
        chk("fullpop_fill", 32'(fill), 32'd15);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        chk("fullpop_head", 32'(out_pix), 32'd501);
        for (int i = 0; i < 15; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        chk("fullpop_drained", 32'(empty), 32'd1);

        // Flush with a push in the same cycle.
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(700 + i), 16'(800 + i), 1'b0, 1'b0);
        chk("pre_flush_fill", 32'(fill), 32'd5);
`ifdef ZFIFO_HWM_EN
        chk("pre_flush_hwm", 32'(hwm), 32'd5);
`endif
        cycle(1'b1, 16'h0bad, 16'h0bad, 1'b0, 1'b1);
        chk("flush_fill", 32'(fill), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
`ifdef ZFIFO_HWM_EN
        chk("flush_hwm", 32'(hwm), 32'd0);
`endif
        cycle(1'b1, 16'h0123, 16'h0456, 1'b0, 1'b0);
        chk("post_flush_head", 32'(out_pix), 32'h0123);
        chk("post_flush_fill", 32'(fill), 32'd1);

        // Asynchronous reset between edges.
        cycle(1'b1, 16'h0aaa, 16'h0bbb, 1'b0, 1'b0);
        cycle(1'b1, 16'h0ccc, 16'h0ddd, 1'b0, 1'b0);
        chk("pre_reset_fill", 32'(fill), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_fill", 32'(fill), 32'd0);
        chk("async_full", 32'(full), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
